sha256_round_ctrl: RTL

Sequencer for the SHA-256 compression core and its message scheduler.
- Accepts 512-bit block requests over a valid/ready handshake.
- Drives the core's clear_hash, load, count and prev_hash inputs through the 64 rounds.
- Chains the intermediate hash across blocks of one message and presents the final digest over a valid/ready handshake.
- Sits between the top-level message/padding front end and the compression core plus scheduler pair.

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha256_round_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing types and constants.
// No logic; types and constants only.
// Not applicable.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD   = 3'd2,
        ROUNDS = 3'd3,
        DONE   = 3'd4
    } ctrl_state_t;

    localparam int         NUM_ROUNDS = 64;
    localparam logic [6:0] COUNT_IDLE = 7'd64;

    // Initial hash value H0..H7, H0 in the top word.
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_round_ctrl.sv
// Sequencer for the SHA-256 compression core and message scheduler.
// Latency: accept->DONE 67 cycles (first block), 66 (chained block).
// Backpressure: blk_ready only in IDLE; digest held in DONE until digest_ready.
//
// Ports:
//   clk, n_rst                 clock, async active-low reset (shared with core)
//   blk_valid/blk_ready        block request handshake; first_blk/last_blk sampled on accept
//   abort                      synchronous cancel, highest priority
//   hash_out                   core hash register
//   clear_hash/load/count      core controls; count also indexes the scheduler
//   prev_hash                  chaining value added by the core at the last round
//   sched_load                 scheduler capture pulse
//   digest/digest_valid/_ready final digest handshake
//   busy, seq_err              status; seq_err flags a non-first block with no chain
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int CNT_W      = 7
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           blk_valid,
    output logic           blk_ready,
    input  logic           first_blk,
    input  logic           last_blk,
    input  logic           abort,
    input  logic [255:0]   hash_out,
    output logic           clear_hash,
    output logic           load,
    output logic [CNT_W-1:0] count,
    output logic [255:0]   prev_hash,
    output logic           sched_load,
    output logic [255:0]   digest,
    output logic           digest_valid,
    input  logic           digest_ready,
    output logic           busy,
    output logic           seq_err
);
    import sha256_pkg::*;

    localparam logic [CNT_W-1:0] CNT_IDLE = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [255:0]     prev_q;
    logic             chain_q;
    logic             last_q;
    logic             seq_err_q;
    logic             accept;
    logic             blk_end;

    assign accept  = (state_q == IDLE) && blk_valid && !abort;
    assign blk_end = (state_q == ROUNDS) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_ready    = 1'b0;
        clear_hash   = 1'b0;
        load         = 1'b1;
        sched_load   = 1'b0;
        digest_valid = 1'b0;
        digest       = '0;
        busy         = (state_q != IDLE);
        count        = cnt_q;
        prev_hash    = prev_q;
        seq_err      = seq_err_q;

        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (accept)
                    state_d = (first_blk || !chain_q) ? CLEAR : LOAD;
            end
            CLEAR: begin
                clear_hash = 1'b1;
                state_d    = LOAD;
            end
            LOAD: begin
                sched_load = 1'b1;
                state_d    = ROUNDS;
            end
            ROUNDS: begin
                load = 1'b0;
                if (blk_end)
                    state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                digest_valid = 1'b1;
                // Core holds in DONE, so hash_out is stable while presented.
                digest       = hash_out;
                if (digest_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort)
            state_d = IDLE;

        // count is 0 throughout LOAD and the first ROUNDS cycle, then steps
        // once per round; the step off the last round lands on the idle value.
        if (abort)
            cnt_d = CNT_IDLE;
        else if (state_d == LOAD)
            cnt_d = '0;
        else if (state_q == ROUNDS && state_d != ROUNDS)
            cnt_d = CNT_IDLE;
        else if (state_q == ROUNDS)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_IDLE;
            prev_q    <= '0;
            chain_q   <= 1'b0;
            last_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Registered so the pulse lines up with the forced CLEAR cycle.
            seq_err_q <= accept && !first_blk && !chain_q;
            if (accept)
                last_q <= last_blk;
            // IV after CLEAR, or the previous block's result when chained.
            if (state_q == LOAD && !abort)
                prev_q <= hash_out;
            if (abort)
                chain_q <= 1'b0;
            else if (blk_end && !last_q)
                chain_q <= 1'b1;
            else if (state_q == DONE && digest_ready)
                chain_q <= 1'b0;
        end
    end

endmodule
